data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/data_memory.sv | 40 ++++
 tb/tb_data_memory.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// data_memory: word-addressed 32-bit data RAM with combinational read and async clear
//
//   clk        in   rising-edge write clock
//   reset      in   asynchronous active-high reset; clears every word, blocks writes
//   MemWrite   in   write enable, sampled on rising clk
//   MemRead    in   combinational read enable
//   Address    in   byte address; bits [1:0] ignored
//   writeData  in   word to store
//   readData   out  addressed word, or 0 when not reading, out of range or in reset
module data_memory #(
   parameter int DEPTH = 256,
   parameter int AW    = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          MemWrite,
   input  logic          MemRead,
   input  logic [AW-1:0] Address,
   input  logic [31:0]   writeData,
   output logic [31:0]   readData
);
   localparam int LW = $clog2(DEPTH);
   logic [31:0]   mem_q [DEPTH];
   logic [31:0]   mem_d [DEPTH];
   logic [LW-1:0] idx;
   logic          in_range;
   assign idx      = Address[LW+1:2];
   // Any set bit above the word index means the word lies beyond DEPTH; this
   // keeps out-of-range writes from aliasing back into the array.
   assign in_range = (Address >> (LW + 2)) == '0;
   always_comb begin
      mem_d = mem_q;
      if (MemWrite && in_range && !reset) mem_d[idx] = writeData;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) mem_q <= '{default: '0};
      else       mem_q <= mem_d;
   // Gating on reset gives zero output immediately, not only once the clear lands.
   assign readData = (MemRead && in_range && !reset) ? mem_q[idx] : 32'h0;
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: scoreboard-driven self-checking bench for data_memory
module tb_data_memory;
   localparam int DEPTH = 256;
   localparam int AW    = 32;
   logic          clk = 1'b0;
   logic          reset;
   logic          MemWrite;
   logic          MemRead;
   logic [AW-1:0] Address;
   logic [31:0]   writeData;
   logic [31:0]   readData;
   logic [31:0]   ref_mem [DEPTH];
   logic [31:0]   exp_q [$];
   string         tag_q [$];
   int            n_cmp = 0;
   int            n_err = 0;

   data_memory #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead),
      .Address(Address), .writeData(writeData), .readData(readData)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: readData=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   function automatic logic ref_in_range(input logic [AW-1:0] a);
      return a[AW-1:2] < DEPTH;
   endfunction

   function automatic logic [31:0] ref_read(input logic [AW-1:0] a);
      return ref_in_range(a) ? ref_mem[a[$clog2(DEPTH)+1:2]] : 32'h0;
   endfunction

   task automatic expect_now(input string tag, input logic [31:0] exp);
      exp_q.push_back(exp);
      tag_q.push_back(tag);
   endtask

   task automatic sample;
      #1;
      check(tag_q.pop_front(), readData, exp_q.pop_front());
   endtask

   task automatic rd(input logic [AW-1:0] a, input string tag, input logic [31:0] exp);
      Address = a;
      MemRead = 1'b1;
      expect_now(tag, exp);
      sample();
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
      @(negedge clk);
      MemRead   = 1'b0;
      MemWrite  = 1'b1;
      Address   = a;
      writeData = d;
      if (ref_in_range(a)) ref_mem[a[$clog2(DEPTH)+1:2]] = d;
      @(negedge clk);
      MemWrite = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      reset     = 1'b1;
      MemWrite  = 1'b0;
      MemRead   = 1'b1;
      Address   = 32'h10;
      writeData = '0;
      #2;
      expect_now("rst_hold", 32'h0);
      sample();
      #7 reset = 1'b0;
      @(negedge clk);
      rd(32'h10, "rst_0x10", 32'h0);
      rd(32'h20, "rst_0x20", 32'h0);
      wr(32'h10, 32'hDEADBEEF);
      rd(32'h10, "wr_0x10", 32'hDEADBEEF);
      MemRead = 1'b0;
      expect_now("rd_off", 32'h0);
      sample();
      wr(32'h20, 32'hCAFEBABE);
      rd(32'h20, "wr_0x20", 32'hCAFEBABE);
      rd(32'h10, "keep_0x10", 32'hDEADBEEF);
      rd(32'h13, "align_0x13", 32'hDEADBEEF);
      wr(4 * DEPTH, 32'h12345678);
      rd(4 * DEPTH, "oor_read", 32'h0);
      rd(32'h0, "no_alias_w0", 32'h0);
      wr(4 * (DEPTH - 1), 32'hA5A5_0001);
      rd(4 * (DEPTH - 1), "last_word", 32'hA5A5_0001);
      rd(4 * (DEPTH - 1) + 3, "last_word_b3", 32'hA5A5_0001);
      @(negedge clk);
      MemWrite  = 1'b0;
      Address   = 32'h20;
      writeData = 32'h5555_AAAA;
      @(negedge clk);
      rd(32'h20, "we_off", 32'hCAFEBABE);
      for (int i = 0; i < 24; i++) begin
         logic [AW-1:0] a;
         a = {22'h0, 10'($urandom_range(0, 4 * DEPTH + 63))};
         if (i % 2 == 0) wr(a, $urandom);
         else rd(a, "rand_rd", ref_read(a));
      end
      for (int i = 0; i < 8; i++) begin
         logic [AW-1:0] a;
         a = 32'(i * 4);
         rd(a, "rand_sweep", ref_read(a));
      end
      wr(32'h10, 32'hDEADBEEF);
      MemRead   = 1'b1;
      MemWrite  = 1'b1;
      Address   = 32'h10;
      writeData = 32'h0BADF00D;
      expect_now("coll_before", 32'hDEADBEEF);
      sample();
      @(posedge clk);
      expect_now("coll_after", 32'h0BADF00D);
      sample();
      @(negedge clk);
      MemWrite  = 1'b1;
      Address   = 32'h20;
      writeData = 32'h7777_7777;
      #2 reset = 1'b1;
      expect_now("rst_async", 32'h0);
      sample();
      @(posedge clk);
      #2 reset = 1'b0;
      MemWrite = 1'b0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      rd(32'h10, "clr_0x10", 32'h0);
      rd(32'h20, "clr_0x20", 32'h0);
      rd(4 * (DEPTH - 1), "clr_last", 32'h0);
      for (int i = 0; i < 6; i++) rd(32'(i * 40), "clr_sweep", ref_read(32'(i * 40)));
      wr(32'h10, 32'h1357_9BDF);
      rd(32'h10, "post_rst_wr", 32'h1357_9BDF);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
